// File: rtl/tff_count_ctrl.sv
// Start/stop sequencer for a bank of T flip-flops counting to a programmable limit.
// Optional TFFC_DOWN_EN adds the dir port and down counting.
module tff_count_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  input  logic             auto_reload,
`ifdef TFFC_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_limit;
  logic             r_auto_reload;
  logic             w_dir_r;
  logic             w_dir_live;
  logic [WIDTH-1:0] w_start_live;
  logic [WIDTH-1:0] w_start_val;
  logic [WIDTH-1:0] w_end_val;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_t_vec;
  logic             w_tc;
  logic             w_accept;

`ifdef TFFC_DOWN_EN
  logic r_dir;
  assign w_dir_r    = r_dir;
  assign w_dir_live = dir;
`else
  assign w_dir_r    = 1'b0;
  assign w_dir_live = 1'b0;
`endif

  assign w_start_live = w_dir_live ? limit : '0;
  assign w_start_val  = w_dir_r ? r_limit : '0;
  assign w_end_val    = w_dir_r ? '0 : r_limit;
  assign w_tc         = (r_state == S_RUN) && (r_q == w_end_val);

  // Ripple toggle chain: bit i flips when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    logic carry;
    w_step = '0;
    carry  = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_step[i] = carry;
`ifdef TFFC_DOWN_EN
      carry = carry & (w_dir_r ? ~r_q[i] : r_q[i]);
`else
      carry = carry & r_q[i];
`endif
    end
  end

  // Next state and toggle vector; loads are expressed as q ^ target
  always_comb begin
    w_state_nxt = r_state;
    w_t_vec     = '0;
    w_accept    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_tc) begin
          if (r_auto_reload) w_t_vec = r_q ^ w_start_val;
          else               w_state_nxt = S_DONE;
        end else begin
          w_t_vec = w_step;
        end
      end
      default: begin
        if (start) begin
          w_accept    = 1'b1;
          w_t_vec     = r_q ^ w_start_live;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_q           <= '0;
      r_limit       <= '0;
      r_auto_reload <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= r_q ^ w_t_vec;
      if (w_accept) begin
        r_limit       <= limit;
        r_auto_reload <= auto_reload;
      end
    end
  end

`ifdef TFFC_DOWN_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_dir <= 1'b0;
    else if (w_accept) r_dir <= dir;
  end
`endif

  assign t_vec = w_t_vec;
  assign q     = r_q;
  assign tc    = w_tc;
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Randomized and directed bench for tff_count_ctrl against an arithmetic counter model.
module tb_tff_count_ctrl;

  localparam int W = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start, stop, auto_reload, dir;
  logic [W-1:0] limit;
  logic [W-1:0] t_vec, q;
  logic         busy, tc, done;

  int checks   = 0;
  int failures = 0;
  string cur_test = "none";

  int           m_st;
  logic [W-1:0] m_q, m_lim;
  logic         m_ar, m_dir;

  always #5 clk = ~clk;

  tff_count_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .limit(limit), .auto_reload(auto_reload),
`ifdef TFFC_DOWN_EN
    .dir(dir),
`endif
    .t_vec(t_vec), .q(q), .busy(busy), .tc(tc), .done(done)
  );

  task automatic model_reset();
    m_st = M_IDLE; m_q = '0; m_lim = '0; m_ar = 1'b0; m_dir = 1'b0;
  endtask

  // Drive one cycle of inputs (called at negedge), check against the model, advance both.
  task automatic tick(input logic s, input logic p, input logic [W-1:0] l,
                      input logic a, input logic d);
    logic [W-1:0] endv, nq, e_t;
    logic         e_tc, d_eff;
    int           nst;
    logic [W-1:0] n_lim;
    logic         n_ar, n_dir;
`ifdef TFFC_DOWN_EN
    d_eff = d;
`else
    d_eff = 1'b0;
`endif
    start = s; stop = p; limit = l; auto_reload = a; dir = d;
    #1;
    endv  = m_dir ? '0 : m_lim;
    e_tc  = (m_st == M_RUN) && (m_q == endv);
    nst = m_st; nq = m_q; n_lim = m_lim; n_ar = m_ar; n_dir = m_dir;
    if (m_st == M_RUN) begin
      if (p) nst = M_IDLE;
      else if (e_tc) begin
        if (m_ar) nq = m_dir ? m_lim : '0;
        else      nst = M_DONE;
      end else nq = m_dir ? m_q - 1 : m_q + 1;
    end else if (s) begin
      nst = M_RUN; nq = d_eff ? l : '0;
      n_lim = l; n_ar = a; n_dir = d_eff;
    end else nst = M_IDLE;
    e_t = m_q ^ nq;

    checks++;
    if (q !== m_q) begin failures++; $display("FAIL %s q got %0h exp %0h", cur_test, q, m_q); end
    checks++;
    if (busy !== (m_st == M_RUN)) begin failures++; $display("FAIL %s busy got %0b exp %0b", cur_test, busy, m_st == M_RUN); end
    checks++;
    if (done !== (m_st == M_DONE)) begin failures++; $display("FAIL %s done got %0b exp %0b", cur_test, done, m_st == M_DONE); end
    checks++;
    if (tc !== e_tc) begin failures++; $display("FAIL %s tc got %0b exp %0b (q=%0h)", cur_test, tc, e_tc, m_q); end
    checks++;
    if (t_vec !== e_t) begin failures++; $display("FAIL %s t_vec got %0h exp %0h (q=%0h)", cur_test, t_vec, e_t, m_q); end

    @(posedge clk);
    m_st = nst; m_q = nq; m_lim = n_lim; m_ar = n_ar; m_dir = n_dir;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    int guard;
    cur_test = "reset";
    tick(1'b1, 1'b0, 8'd9, 1'b0, 1'b0);
    guard = 0;
    while (m_q != 8'd5 && guard < 40) begin tick(1'b0, 1'b0, '0, 1'b0, 1'b0); guard++; end
    checks++;
    if (guard >= 40) begin failures++; $display("FAIL reset_reach_q5 got guard %0d exp <40", guard); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0 || t_vec !== '0) begin
      failures++;
      $display("FAIL reset_async got q=%0h busy=%0b done=%0b tc=%0b t=%0h exp all 0", q, busy, done, tc, t_vec);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_oneshot();
    int nbusy = 0;
    cur_test = "oneshot_l3";
    tick(1'b1, 1'b0, 8'd3, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (busy) nbusy++;
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    checks++;
    if (nbusy !== 4) begin failures++; $display("FAIL oneshot_run_len got %0d exp 4", nbusy); end
  endtask

  task automatic test_autoreload();
    int guard = 0;
    cur_test = "autoreload_l2";
    tick(1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
    idle(10);
    while (m_q != 8'd1 && guard < 10) begin idle(1); guard++; end
    tick(1'b0, 1'b1, '0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || q !== 8'd1) begin failures++; $display("FAIL autoreload_stop got busy=%0b q=%0h exp busy=0 q=1", busy, q); end
    idle(3);
  endtask

  task automatic test_limit_zero();
    cur_test = "limit0_oneshot";
    tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    idle(3);
    cur_test = "limit0_reload";
    tick(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    idle(6);
    tick(1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_stop_tc();
    int guard = 0;
    cur_test = "stop_tc";
    tick(1'b1, 1'b0, 8'd4, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'd77, 1'b1, 1'b1);
    while (m_q != 8'd4 && guard < 20) begin idle(1); guard++; end
    tick(1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle(3);
  endtask

  task automatic test_restart_from_done();
    int guard = 0;
    cur_test = "restart_done";
    tick(1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
    while (m_st != M_DONE && guard < 10) begin idle(1); guard++; end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL restart_done_seen got %0b exp 1", done); end
    tick(1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
    idle(6);
  endtask

  task automatic test_random();
    logic [W-1:0] l;
    cur_test = "random";
    for (int i = 0; i < 500; i++) begin
      l = ($urandom % 4 == 0) ? W'($urandom) : W'($urandom % 8);
      tick(($urandom % 6) == 0, ($urandom % 12) == 0, l, 1'($urandom), 1'($urandom));
    end
    tick(1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle(2);
  endtask

`ifdef TFFC_DOWN_EN
  task automatic test_down();
    int nbusy = 0;
    cur_test = "down_a5";
    tick(1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
    for (int i = 0; i < 170; i++) begin
      if (busy) nbusy++;
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    checks++;
    if (nbusy !== 166) begin failures++; $display("FAIL down_run_len got %0d exp 166", nbusy); end
  endtask
`endif

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; limit = '0; auto_reload = 1'b0; dir = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    cur_test = "post_reset";
    idle(2);
    test_reset();
    test_oneshot();
    test_autoreload();
    test_limit_zero();
    test_stop_tc();
    test_restart_from_done();
`ifdef TFFC_DOWN_EN
    test_down();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
